// File: rtl/cgra_im_bank.sv
// Instruction-memory bank for the CGRA: NUM_ID decoder memories plus NUM_IMM immediate
// memories, filled by a header/data streaming loader and read through registered fetch ports.
module cgra_im_bank #(
  parameter int I_WIDTH           = 12,
  parameter int I_IMM_WIDTH       = 33,
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int NUM_ID            = 6,
  parameter int NUM_IMM           = 3,
  parameter int LD_WIDTH          = 33
) (
  input  logic                                            iClk,
  input  logic                                            iReset_n,
  input  logic                                            iLoad_Hold,
  input  logic                                            iLoad_Valid,
  output logic                                            oLoad_Ready,
  input  logic [LD_WIDTH-1:0]                             iLoad_Data,
  output logic                                            oLoad_Busy,
  output logic                                            oLoad_Done,
  output logic                                            oLoad_Error,
  input  logic [NUM_ID+NUM_IMM-1:0]                       iIM_ReadEnable,
  input  logic [(NUM_ID+NUM_IMM)*IM_MEM_ADDR_WIDTH-1:0]   iIM_ReadAddress,
  output logic [NUM_ID*I_WIDTH+NUM_IMM*I_IMM_WIDTH-1:0]   oIM_ReadData
);

  localparam int AW      = IM_MEM_ADDR_WIDTH;
  localparam int NUM_MEM = NUM_ID + NUM_IMM;
  localparam int TW      = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam int DEPTH   = 1 << AW;
  localparam logic [TW:0] NUM_MEM_L = (TW+1)'(NUM_MEM);

  typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [AW-1:0] count, count_nxt;
  logic [TW-1:0] target, target_nxt;
  logic          error, error_nxt;
  logic          done, done_nxt;
  logic          accept, wr_en, hdr_ok;

  logic [AW-1:0] hdr_s, hdr_l;
  logic [TW-1:0] hdr_t;

  assign hdr_s  = iLoad_Data[AW-1:0];
  assign hdr_l  = iLoad_Data[2*AW-1:AW];
  assign hdr_t  = iLoad_Data[2*AW+TW-1:2*AW];
  assign hdr_ok = ({1'b0, hdr_t} < NUM_MEM_L);

  assign oLoad_Ready = iReset_n & ~iLoad_Hold;
  assign accept      = iLoad_Valid & oLoad_Ready;
  assign wr_en       = accept & (state == DATA);
  assign oLoad_Busy  = (state != IDLE);
  assign oLoad_Done  = done;
  assign oLoad_Error = error;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state  <= IDLE;
      addr   <= '0;
      count  <= '0;
      target <= '0;
      error  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      count  <= count_nxt;
      target <= target_nxt;
      error  <= error_nxt;
      done   <= done_nxt;
    end
  end

  // count holds words remaining minus one, so the final word is the one seen at count == 0
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    count_nxt  = count;
    target_nxt = target;
    error_nxt  = error;
    done_nxt   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          count_nxt = hdr_l;
          if (hdr_ok) begin
            addr_nxt   = hdr_s;
            target_nxt = hdr_t;
            error_nxt  = 1'b0;
            state_nxt  = DATA;
          end else begin
            error_nxt  = 1'b1;
            state_nxt  = DRAIN;
          end
        end
        DATA, DRAIN: begin
          if (state == DATA) addr_nxt = addr + 1'b1;
          if (count == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            count_nxt = count - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_ID; k++) begin : g_id
    logic [I_WIDTH-1:0] mem [DEPTH];
    logic [I_WIDTH-1:0] q;

    always_ff @(posedge iClk)
      if (wr_en && target == TW'(k)) mem[addr] <= iLoad_Data[I_WIDTH-1:0];

    always_ff @(posedge iClk or negedge iReset_n)
      if (!iReset_n)              q <= '0;
      else if (iIM_ReadEnable[k]) q <= mem[iIM_ReadAddress[k*AW +: AW]];

    assign oIM_ReadData[k*I_WIDTH +: I_WIDTH] = q;
  end

  for (genvar j = 0; j < NUM_IMM; j++) begin : g_imm
    localparam int K = NUM_ID + j;
    logic [I_IMM_WIDTH-1:0] mem [DEPTH];
    logic [I_IMM_WIDTH-1:0] q;

    always_ff @(posedge iClk)
      if (wr_en && target == TW'(K)) mem[addr] <= iLoad_Data[I_IMM_WIDTH-1:0];

    always_ff @(posedge iClk or negedge iReset_n)
      if (!iReset_n)              q <= '0;
      else if (iIM_ReadEnable[K]) q <= mem[iIM_ReadAddress[K*AW +: AW]];

    assign oIM_ReadData[NUM_ID*I_WIDTH + j*I_IMM_WIDTH +: I_IMM_WIDTH] = q;
  end

endmodule
